// File: rtl/storage_arbiter_pkg.sv
// Shared types and default sizing for the storage port arbiter.
// The request struct is sized for the default address/data widths.
package storage_arbiter_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int TIMEOUT_DEF      = 255;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_e;

    typedef struct packed {
        logic                      we;
        logic [ADDR_W_DEF-1:0]     addr;
        logic [DATA_W_DEF-1:0]     wdata;
        logic [DATA_W_DEF/8-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/storage_arbiter_pick.sv
// Starvation-aware winner select between fetch and load/store.
// The starvation count only moves on cycles where a grant is actually made.
module storage_arbiter_pick
    import storage_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   ls_req,
    output owner_e winner,
    output logic   valid
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    always_comb begin
        starved = (starve_cnt == CW'(STARVE_LIMIT));
        valid   = arb_en && (if_req || ls_req);
        winner  = (if_req && (!ls_req || starved)) ? OWN_IF : OWN_LS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (valid) begin
            if (winner == OWN_IF || !if_req) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/storage_arbiter.sv
// Shares the storage_controller port between instruction fetch and load/store.
// Each grant runs ISSUE -> WAIT -> DONE; prog_mode blocks new grants only.
module storage_arbiter
    import storage_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                prog_mode,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_done,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                err,
    output logic                busy,
    output logic                memory_access,
    output logic                memory_is_writing,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   d_in,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   d_out,
    input  logic                out_valid
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e              state, state_nxt;
    owner_e              owner_q, pick_winner;
    logic                pick_valid;
    logic                grant, capture, tmo_hit, bus_on;
    logic                we_q, err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic [TW-1:0]       tmo_cnt;

    storage_arbiter_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk    (clk),
        .rst    (rst),
        .arb_en (state == IDLE && !prog_mode),
        .if_req (if_req),
        .ls_req (ls_req),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                capture   = out_valid;
                state_nxt = out_valid ? DONE : WAIT;
            end
            WAIT: begin
                if (out_valid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        bus_on            = (state == ISSUE) || (state == WAIT);
        busy              = (state != IDLE);
        memory_access     = (state == ISSUE);
        memory_is_writing = bus_on && we_q;
        addr              = bus_on ? addr_q  : '0;
        d_in              = bus_on ? wdata_q : '0;
        mem_be            = bus_on ? be_q    : '0;
        if_done           = (state == DONE) && (owner_q == OWN_IF);
        ls_done           = (state == DONE) && (owner_q == OWN_LS);
        if_rdata          = if_done ? rdata_q : '0;
        ls_rdata          = ls_done ? rdata_q : '0;
        err               = (state == DONE) && err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_q <= pick_winner;
                if (pick_winner == OWN_IF) begin
                    we_q    <= 1'b0;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                    be_q    <= '1;
                end else begin
                    we_q    <= ls_we;
                    addr_q  <= ls_addr;
                    wdata_q <= ls_wdata;
                    be_q    <= ls_be;
                end
            end
            // Writes complete with zero read data so the LSU never sees stale bus values.
            if (capture) begin
                rdata_q <= we_q ? '0 : d_out;
                err_q   <= 1'b0;
            end else if (tmo_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (state == DONE) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            tmo_cnt <= (state == WAIT && state_nxt == WAIT) ? tmo_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_storage_arbiter.sv
// Bench for storage_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_storage_arbiter;
    import storage_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    logic        clk;
    logic        rst, prog_mode;
    logic        if_req, ls_req, ls_we, out_valid;
    logic [31:0] if_addr, ls_addr, ls_wdata, d_out;
    logic [3:0]  ls_be;
    logic        if_done, ls_done, err, busy, memory_access, memory_is_writing;
    logic [31:0] if_rdata, ls_rdata, addr, d_in;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    storage_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_done(ls_done), .ls_rdata(ls_rdata), .err(err), .busy(busy),
        .memory_access(memory_access), .memory_is_writing(memory_is_writing),
        .addr(addr), .d_in(d_in), .mem_be(mem_be), .d_out(d_out), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one transaction record; age counts cycles since grant (1 = strobe cycle).
    bit          m_act, m_fin, m_err;
    int          m_age, m_starve;
    owner_e      m_own;
    mem_req_t    m_pay;
    logic [31:0] m_rdata;
    logic        m_if_wins;

    assign m_if_wins = if_req && (!ls_req || m_starve == STARVE_LIMIT);

    always @(posedge clk) begin
        if (rst) begin
            m_act <= 0; m_fin <= 0; m_err <= 0; m_age <= 0; m_starve <= 0; m_rdata <= '0;
        end else if (m_fin) begin
            m_act <= 0; m_fin <= 0;
        end else if (m_act) begin
            if (out_valid) begin
                m_fin <= 1; m_err <= 0; m_rdata <= m_pay.we ? 32'h0 : d_out;
            end else if (m_age - 1 == TIMEOUT) begin
                m_fin <= 1; m_err <= 1; m_rdata <= '0;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (!prog_mode && (if_req || ls_req)) begin
            m_act <= 1; m_age <= 1;
            if (m_if_wins) begin
                m_own <= OWN_IF; m_starve <= 0;
                m_pay <= {1'b0, if_addr, 32'h0, 4'hF};
            end else begin
                m_own <= OWN_LS;
                m_pay <= {ls_we, ls_addr, ls_wdata, ls_be};
                m_starve <= !if_req ? 0 : (m_starve == STARVE_LIMIT ? m_starve : m_starve + 1);
            end
        end
    end

    always @(negedge clk) begin
        logic on;
        on = m_act && !m_fin;
        chk("busy", busy, m_act);
        chk("memory_access", memory_access, on && m_age == 1);
        chk("memory_is_writing", memory_is_writing, on && m_pay.we);
        chk("addr", addr, on ? m_pay.addr : 32'h0);
        chk("d_in", d_in, on ? m_pay.wdata : 32'h0);
        chk("mem_be", mem_be, on ? m_pay.be : 4'h0);
        chk("if_done", if_done, m_fin && m_own == OWN_IF);
        chk("ls_done", ls_done, m_fin && m_own == OWN_LS);
        chk("if_rdata", if_rdata, (m_fin && m_own == OWN_IF) ? m_rdata : 32'h0);
        chk("ls_rdata", ls_rdata, (m_fin && m_own == OWN_LS) ? m_rdata : 32'h0);
        chk("err", err, m_fin && m_err);
    end

    // Stimulus driver; resp_mode 0 = silent, 1 = out_valid one cycle after strobe, 2 = random
    int          resp_mode = 0;
    bit          rnd_on = 0;
    logic [31:0] dout_fix = '0;

    task automatic step();
        @(negedge clk);
        case (resp_mode)
            0: out_valid = 1'b0;
            1: begin out_valid = m_act && !m_fin && m_age == 2; d_out = dout_fix; end
            default: begin out_valid = ($urandom_range(0, 3) == 0); d_out = $urandom; end
        endcase
        if (rnd_on) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) prog_mode = !prog_mode;
            if (m_fin && m_own == OWN_IF) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (m_fin && m_own == OWN_LS) ls_req = 1'b0;
            else if (!ls_req && $urandom_range(0, 2) == 0) begin
                ls_req = 1'b1; ls_we = $urandom_range(0, 1); ls_addr = $urandom;
                ls_wdata = $urandom; ls_be = 4'($urandom);
            end
        end
    endtask

    task automatic wait_done(input bit is_if, input int budget, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!(is_if ? if_done : ls_done) && cyc < budget);
        chk(is_if ? "if_done_seen" : "ls_done_seen", is_if ? if_done : ls_done, 1'b1);
    endtask

    initial begin
        int     cyc, n;
        owner_e got [6];
        owner_e want [6];
        want[0] = OWN_LS; want[1] = OWN_LS; want[2] = OWN_LS;
        want[3] = OWN_LS; want[4] = OWN_IF; want[5] = OWN_LS;

        rst = 1; prog_mode = 0; if_req = 0; ls_req = 0; ls_we = 0; out_valid = 0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_be = '0; d_out = '0;
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_access", memory_access, 1'b0);
        chk("rst_addr", addr, 32'h0);

        // LS write with out_valid one cycle after the strobe
        rst = 0; resp_mode = 1;
        ls_req = 1; ls_we = 1; ls_addr = 32'h10; ls_wdata = 32'hDEADBEEF; ls_be = 4'hF;
        step();
        chk("wr_access", memory_access, 1'b1);
        chk("wr_addr", addr, 32'h10);
        chk("wr_d_in", d_in, 32'hDEADBEEF);
        chk("wr_is_writing", memory_is_writing, 1'b1);
        step();
        chk("wr_access_once", memory_access, 1'b0);
        step();
        chk("wr_ls_done", ls_done, 1'b1);
        chk("wr_err", err, 1'b0);
        ls_req = 0;

        // IF read returning the written word
        step();
        if_req = 1; if_addr = 32'h10; dout_fix = 32'hDEADBEEF;
        step();
        chk("rd_addr", addr, 32'h10);
        chk("rd_is_writing", memory_is_writing, 1'b0);
        chk("rd_be", mem_be, 4'hF);
        step(); step();
        chk("rd_if_done", if_done, 1'b1);
        chk("rd_if_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 0;

        // Both requesting continuously: starvation forces IF on the 5th grant
        step();
        if_req = 1; if_addr = 32'h100; ls_req = 1; ls_we = 0; ls_addr = 32'h200;
        dout_fix = 32'h12345678;
        n = 0; cyc = 0;
        while (n < 6 && cyc < 60) begin
            step(); cyc++;
            if (ls_done) begin got[n] = OWN_LS; n++; end
            else if (if_done) begin got[n] = OWN_IF; n++; end
        end
        chk("starve_count", n, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("starve_order%0d", i), got[i], want[i]);

        // prog_mode blocks grants while both requests are pending
        prog_mode = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("prog_access", memory_access, 1'b0);
            chk("prog_busy", busy, 1'b0);
        end
        prog_mode = 0;
        step();
        chk("prog_release_access", memory_access, 1'b1);
        chk("prog_release_ls", addr, 32'h200);
        wait_done(0, 10, cyc);
        ls_req = 0;
        wait_done(1, 10, cyc);
        if_req = 0;

        // No response: timeout after 255 WAIT cycles
        step();
        resp_mode = 0; ls_req = 1; ls_we = 0; ls_addr = 32'h40;
        wait_done(0, 300, cyc);
        chk("tmo_latency", cyc, 257);
        chk("tmo_err", err, 1'b1);
        chk("tmo_rdata", ls_rdata, 32'h0);
        ls_req = 0;
        step();
        resp_mode = 1; dout_fix = 32'hA5A5_5A5A; ls_req = 1; ls_addr = 32'h44;
        wait_done(0, 10, cyc);
        chk("post_tmo_latency", cyc, 3);
        chk("post_tmo_err", err, 1'b0);
        chk("post_tmo_rdata", ls_rdata, 32'hA5A5_5A5A);
        ls_req = 0;

        // Reset while waiting drops the transaction
        step();
        resp_mode = 0; ls_req = 1; ls_we = 1; ls_addr = 32'h80; ls_wdata = 32'h1; ls_be = 4'h3;
        step(); step();
        rst = 1;
        step();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_access", memory_access, 1'b0);
        chk("mid_rst_done", ls_done, 1'b0);
        chk("mid_rst_addr", addr, 32'h0);
        rst = 0; resp_mode = 1;
        wait_done(0, 10, cyc);
        chk("rerequest_latency", cyc, 3);
        chk("rerequest_err", err, 1'b0);
        ls_req = 0;

        // Randomized traffic
        resp_mode = 2; rnd_on = 1;
        repeat (4000) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
